spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter FRAME_WIDTH, default 32: SPI frame width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096: watchdog limit in clk_i cycles, used only when SPI_ARB_TIMEOUT_EN is defined.
REQ-004 clk_i  input  1  single clock; every flop in the block is on its rising edge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 req_i  input  NUM_REQ  per-requester transfer request, level held until acked.
REQ-007 req_data_i  input  NUM_REQ*FRAME_WIDTH  per-requester TX frame; slice k = bits [k*FRAME_WIDTH +: FRAME_WIDTH].
REQ-008 ack_o  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-009 rsp_data_o  output  FRAME_WIDTH  received frame, valid in the cycle ack_o pulses.
REQ-010 err_o  output  1  timeout flag, valid with ack_o; tied 0 when SPI_ARB_TIMEOUT_EN is not defined.
REQ-011 dev_sel_o  output  $clog2(NUM_REQ)  index of the granted requester, used for external /CS steering.
REQ-012 spi_start_o  output  1  start strobe to the SPI controller.
REQ-013 spi_idle_i  input  1  controller idle indication.
REQ-014 spi_data_o  output  FRAME_WIDTH  TX frame driven to the controller.
REQ-015 spi_data_i  input  FRAME_WIDTH  RX frame from the controller, valid when spi_idle_i is 1 after a transfer.
REQ-016 spi_rst_o  output  1  controller reset request, driven by the timeout path only.

Function
REQ-017 Four-state FSM:
- IDLE
- LAUNCH
- BUSY
- DONE
REQ-018 IDLE: when any req_i bit is 1 and spi_idle_i is 1, the block shall select a winner round-robin, starting the search at index rr_ptr, and move to LAUNCH; it shall register the winner index into dev_sel_o and the winner's req_data_i slice into spi_data_o in the same edge.
REQ-019 rr_ptr shall reset to 0.
REQ-020 In DONE, rr_ptr shall be set to (grant+1) mod NUM_REQ.
REQ-021 LAUNCH: spi_start_o shall be 1; the FSM shall move to BUSY on the first cycle spi_idle_i is 0.
REQ-022 BUSY: spi_start_o shall be 0, so the controller cannot retrigger; on the first cycle spi_idle_i is 1, the block shall capture spi_data_i into rsp_data_o and move to DONE.
REQ-023 DONE: ack_o[dev_sel_o] shall be 1 for exactly one cycle, with rsp_data_o stable; the FSM then returns to IDLE.
REQ-024 A requester shall hold req_i and req_data_i stable until its ack; the block samples req_data_i only on the grant edge.
REQ-025 A requester deasserting req_i after grant shall not abort the transfer; the ack is still issued.
REQ-026 Minimum latency from the grant edge to ack is 3 cycles plus the controller busy time.
REQ-027 The earliest re-grant is the cycle after DONE.
REQ-028 A requester shall receive at most one grant per full rotation while others are requesting; no requester may be starved.
REQ-029 Requests arriving during LAUNCH, BUSY or DONE shall be held off until the FSM returns to IDLE, with no loss and no queueing inside the block.
REQ-030 dev_sel_o and spi_data_o shall hold their values from the grant edge until the next grant.

Reset
REQ-031 Reset values:
- FSM in IDLE
- rr_ptr = 0
- ack_o = 0
- rsp_data_o = 0
- err_o = 0
- dev_sel_o = 0
- spi_start_o = 0
- spi_data_o = 0
- spi_rst_o = 0
REQ-032 Reset asserted mid-transfer shall abandon the transfer with no ack; requesters re-request after reset.

Configuration
REQ-033 Macro SPI_ARB_TIMEOUT_EN, when defined, enables a watchdog counter that clears on entry to LAUNCH and increments in LAUNCH and BUSY.
REQ-034 With SPI_ARB_TIMEOUT_EN defined, a count reaching TIMEOUT_CYCLES shall cause the block to:
- assert spi_rst_o for one cycle;
- force rsp_data_o to 0;
- enter DONE with err_o = 1 alongside ack_o.
REQ-035 Without SPI_ARB_TIMEOUT_EN, no watchdog logic exists, err_o and spi_rst_o are constant 0, and the block waits indefinitely.

Verification
REQ-036 Single request: req_i=4'b0001, req_data_i[31:0]=32'hA5A5_0F0F, controller model echoes the frame -> spi_start_o seen, ack_o=4'b0001 once, rsp_data_o=32'hA5A5_0F0F, dev_sel_o=0.
REQ-037 All four requesting continuously from reset -> grant order 0,1,2,3,0; each ack carries that requester's own echoed frame.
REQ-038 req_i=4'b1010 after rr_ptr=2 -> first grant is 3, then 1.
REQ-039 Controller held busy 10 cycles -> spi_start_o drops the cycle after spi_idle_i falls; ack arrives 1 cycle after spi_idle_i rises; exactly one controller transfer occurs.
REQ-040 reset_i pulsed during BUSY -> no ack_o, all outputs at reset values, next grant goes to index 0.
REQ-041 SPI_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and spi_idle_i stuck 0 -> spi_rst_o pulses once, ack with err_o=1 and rsp_data_o=0, FSM returns to IDLE.

Source files
------------

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter that shares one SPI controller among NUM_REQ requesters.
// A grant latches the winner index and its TX frame. The FSM then launches the controller,
// waits for it to finish and returns the RX frame with a one-cycle ack to the winner.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort transfers that exceed TIMEOUT_CYCLES.

module spi_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned FRAME_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*FRAME_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]             ack_o,
    output logic [FRAME_WIDTH-1:0]         rsp_data_o,
    output logic                           err_o,
    output logic [$clog2(NUM_REQ)-1:0]     dev_sel_o,
    output logic                           spi_start_o,
    input  logic                           spi_idle_i,
    output logic [FRAME_WIDTH-1:0]         spi_data_o,
    input  logic [FRAME_WIDTH-1:0]         spi_data_i,
    output logic                           spi_rst_o
);

    localparam int unsigned SelW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StBusy,
        StDone
    } state_e;

    state_e                 state_q;
    logic [SelW-1:0]        rr_ptr_q;
    logic [SelW-1:0]        dev_sel_q;
    logic [NUM_REQ-1:0]     ack_q;
    logic [FRAME_WIDTH-1:0] rsp_data_q;
    logic [FRAME_WIDTH-1:0] spi_data_q;
    logic                   spi_start_q;

    logic                   grant_found;
    logic [SelW-1:0]        grant_idx;
    logic [SelW-1:0]        cand_idx;
    logic [FRAME_WIDTH-1:0] grant_data;
    logic [SelW-1:0]        rr_next;
    logic [NUM_REQ-1:0]     ack_next;
    logic                   timeout_hit;

    // Round-robin search: first requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand_idx = SelW'((int'(rr_ptr_q) + i) % int'(NUM_REQ));
            if (!grant_found && req_i[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Mux out the winner's TX frame, next pointer and one-hot ack for the current grant.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (grant_idx == SelW'(k)) begin
                grant_data = req_data_i[k*FRAME_WIDTH +: FRAME_WIDTH];
            end
        end
        rr_next = (dev_sel_q == SelW'(NUM_REQ - 1)) ? '0 : dev_sel_q + SelW'(1);
        ack_next = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            ack_next[k] = (dev_sel_q == SelW'(k));
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WdW-1:0] wd_q;
    logic           err_q;
    logic           spi_rst_q;

    // Fires on the cycle the count would reach the limit while a transfer is outstanding;
    // a BUSY cycle that sees the controller go idle completes normally instead.
    assign timeout_hit = ((state_q == StLaunch) || ((state_q == StBusy) && !spi_idle_i)) &&
                         (wd_q == WdW'(TIMEOUT_CYCLES - 1));

    // Watchdog counter plus the one-cycle error and controller-reset pulses.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wd_q      <= '0;
            err_q     <= 1'b0;
            spi_rst_q <= 1'b0;
        end else begin
            if (state_q == StIdle) begin
                wd_q <= '0;
            end else if ((state_q == StLaunch) || (state_q == StBusy)) begin
                wd_q <= wd_q + WdW'(1);
            end
            err_q     <= timeout_hit;
            spi_rst_q <= timeout_hit;
        end
    end

    assign err_o     = err_q;
    assign spi_rst_o = spi_rst_q;
`else
    // Watchdog absent: the transfer waits on the controller indefinitely.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign err_o              = 1'b0;
    assign spi_rst_o          = 1'b0;
`endif

    // Main FSM; every output is a register updated on the state transitions.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            dev_sel_q   <= '0;
            ack_q       <= '0;
            rsp_data_q  <= '0;
            spi_data_q  <= '0;
            spi_start_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_found && spi_idle_i) begin
                        dev_sel_q   <= grant_idx;
                        spi_data_q  <= grant_data;
                        spi_start_q <= 1'b1;
                        state_q     <= StLaunch;
                    end
                end
                StLaunch: begin
                    if (timeout_hit) begin
                        spi_start_q <= 1'b0;
                        rsp_data_q  <= '0;
                        ack_q       <= ack_next;
                        state_q     <= StDone;
                    end else if (!spi_idle_i) begin
                        // Controller has accepted the start; drop it so it cannot retrigger.
                        spi_start_q <= 1'b0;
                        state_q     <= StBusy;
                    end
                end
                StBusy: begin
                    if (spi_idle_i) begin
                        rsp_data_q <= spi_data_i;
                        ack_q      <= ack_next;
                        state_q    <= StDone;
                    end else if (timeout_hit) begin
                        rsp_data_q <= '0;
                        ack_q      <= ack_next;
                        state_q    <= StDone;
                    end
                end
                StDone: begin
                    ack_q    <= '0;
                    rr_ptr_q <= rr_next;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ack_o       = ack_q;
    assign rsp_data_o  = rsp_data_q;
    assign dev_sel_o   = dev_sel_q;
    assign spi_start_o = spi_start_q;
    assign spi_data_o  = spi_data_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed and randomized checks of spi_arbiter against a queue-free
// round-robin reference model and a simple SPI controller model.
// Build with SPI_ARB_TIMEOUT_EN defined to include the watchdog scenario.

module tb_spi_arbiter;

    localparam int NR = 4;
    localparam int FW = 32;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req;
    logic [NR*FW-1:0] req_data;
    logic [NR-1:0]    ack;
    logic [FW-1:0]    rsp;
    logic             err;
    logic [1:0]       dev_sel;
    logic             spi_start;
    logic             spi_idle;
    logic [FW-1:0]    spi_wdata;
    logic [FW-1:0]    spi_rdata;
    logic             spi_rst;

    int n_cmp  = 0;
    int n_fail = 0;

    // Controller model knobs
    int            ctrl_busy  = 0;
    bit            ctrl_stuck = 1'b0;
    logic [FW-1:0] ctrl_xor   = '0;
    int            xfer_cnt   = 0;

    spi_arbiter #(
        .NUM_REQ       (NR),
        .FRAME_WIDTH   (FW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .req_i      (req),
        .req_data_i (req_data),
        .ack_o      (ack),
        .rsp_data_o (rsp),
        .err_o      (err),
        .dev_sel_o  (dev_sel),
        .spi_start_o(spi_start),
        .spi_idle_i (spi_idle),
        .spi_data_o (spi_wdata),
        .spi_data_i (spi_rdata),
        .spi_rst_o  (spi_rst)
    );

    always #5 clk = ~clk;

    // SPI controller: goes busy on a start, stays busy ctrl_busy+1 cycles, returns tx^ctrl_xor.
    initial begin
        logic [FW-1:0] tx;
        int            cnt;
        bit            active;
        tx = '0;
        cnt = 0;
        active = 1'b0;
        spi_idle = 1'b1;
        spi_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset || spi_rst) begin
                active   = 1'b0;
                spi_idle = 1'b1;
            end else if (!active) begin
                if (spi_start) begin
                    active = 1'b1;
                    xfer_cnt++;
                    tx = spi_wdata;
                    spi_idle = 1'b0;
                    cnt = ctrl_busy;
                end
            end else if (!ctrl_stuck) begin
                if (cnt == 0) begin
                    spi_rdata = tx ^ ctrl_xor;
                    spi_idle = 1'b1;
                    active = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 50000 cycles");
        $fatal(1, "global timeout");
    end

    function automatic logic [FW-1:0] get_data(input int k);
        return req_data[k*FW +: FW];
    endfunction

    task automatic set_data(input int k, input logic [FW-1:0] v);
        req_data[k*FW +: FW] = v;
    endtask

    // Reference arbitration: first requester at or after p, modulo NR.
    function automatic int rr_pick(input logic [NR-1:0] r, input int p);
        for (int i = 0; i < NR; i++) begin
            if (((r >> ((p + i) % NR)) & NR'(1)) != '0) return (p + i) % NR;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req = '0;
        ctrl_stuck = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ack(input int budget, output bit seen, output bit saw_start);
        seen = 1'b0;
        saw_start = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (spi_start) saw_start = 1'b1;
            if (ack != '0) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        req = 4'b1111;
        req_data = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(negedge clk);
        n_cmp++; if (ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack); end
        n_cmp++; if (rsp !== '0) begin n_fail++; $display("FAIL reset_rsp: got %h want 0", rsp); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (dev_sel !== '0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", dev_sel); end
        n_cmp++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", spi_start); end
        n_cmp++; if (spi_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", spi_wdata); end
        n_cmp++; if (spi_rst !== 1'b0) begin n_fail++; $display("FAIL reset_spirst: got %b want 0", spi_rst); end
        req = '0;
        reset = 1'b0;
    endtask

    task automatic test_single();
        bit seen, saw_start;
        int extra;
        do_reset();
        ctrl_xor = '0;
        ctrl_busy = 2;
        set_data(0, 32'hA5A5_0F0F);
        req = 4'b0001;
        wait_ack(40, seen, saw_start);
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL single_ack_seen: got none want ack"); end
        n_cmp++; if (!saw_start) begin n_fail++; $display("FAIL single_start: got 0 want 1"); end
        n_cmp++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b want 0001", ack); end
        n_cmp++; if (rsp !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL single_rsp: got %h want a5a50f0f", rsp); end
        n_cmp++; if (dev_sel !== 2'd0) begin n_fail++; $display("FAIL single_sel: got %0d want 0", dev_sel); end
        req = '0;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack != '0) extra++;
        end
        n_cmp++; if (extra != 0) begin n_fail++; $display("FAIL single_ack_once: got %0d extra want 0", extra); end
    endtask

    task automatic test_all_four();
        bit seen, saw_start;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [FW-1:0] exp_rsp;
        do_reset();
        ctrl_xor = $urandom;
        ctrl_busy = 1;
        for (int k = 0; k < NR; k++) set_data(k, $urandom);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_rsp = get_data(exp_order[n]) ^ ctrl_xor;
            wait_ack(40, seen, saw_start);
            n_cmp++;
            if (ack !== (NR'(1) << exp_order[n])) begin
                n_fail++; $display("FAIL all4_order%0d: got %b want idx %0d", n, ack, exp_order[n]);
            end
            n_cmp++;
            if (rsp !== exp_rsp) begin
                n_fail++; $display("FAIL all4_rsp%0d: got %h want %h", n, rsp, exp_rsp);
            end
            set_data(exp_order[n], $urandom);
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ptr2();
        bit seen, saw_start;
        do_reset();
        ctrl_busy = 0;
        for (int k = 0; k < NR; k++) set_data(k, $urandom);
        req = 4'b0010;
        wait_ack(40, seen, saw_start);
        n_cmp++; if (dev_sel !== 2'd1) begin n_fail++; $display("FAIL ptr2_setup: got %0d want 1", dev_sel); end
        req = 4'b1010;
        wait_ack(40, seen, saw_start);
        n_cmp++; if (ack !== 4'b1000) begin n_fail++; $display("FAIL ptr2_first: got %b want 1000", ack); end
        req = 4'b0010;
        wait_ack(40, seen, saw_start);
        n_cmp++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL ptr2_second: got %b want 0010", ack); end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_busy_hold();
        int t_fall, t_rise, t_ack, n_ack, x0;
        logic start_at_fall, start_after_fall, prev_idle;
        logic [FW-1:0] exp_rsp;
        do_reset();
        ctrl_busy = 9;
        ctrl_xor = $urandom;
        set_data(2, $urandom);
        exp_rsp = get_data(2) ^ ctrl_xor;
        t_fall = -1; t_rise = -1; t_ack = -1; n_ack = 0;
        start_at_fall = 1'bx; start_after_fall = 1'bx;
        prev_idle = 1'b1;
        x0 = xfer_cnt;
        req = 4'b0100;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (!spi_idle && prev_idle && t_fall < 0) begin
                t_fall = t;
                start_at_fall = spi_start;
            end
            if (t_fall >= 0 && t == t_fall + 1) start_after_fall = spi_start;
            if (spi_idle && !prev_idle && t_rise < 0) t_rise = t;
            if (ack != '0) begin
                n_ack++;
                if (t_ack < 0) begin
                    t_ack = t;
                    n_cmp++;
                    if (rsp !== exp_rsp) begin
                        n_fail++; $display("FAIL busy_rsp: got %h want %h", rsp, exp_rsp);
                    end
                end
                req = '0;
            end
            prev_idle = spi_idle;
        end
        n_cmp++; if (start_at_fall !== 1'b1) begin n_fail++; $display("FAIL busy_start_at_fall: got %b want 1", start_at_fall); end
        n_cmp++; if (start_after_fall !== 1'b0) begin n_fail++; $display("FAIL busy_start_drop: got %b want 0", start_after_fall); end
        n_cmp++; if (t_rise - t_fall != 10) begin n_fail++; $display("FAIL busy_len: got %0d want 10", t_rise - t_fall); end
        n_cmp++; if (t_ack != t_rise + 1) begin n_fail++; $display("FAIL busy_ack_lat: got %0d want %0d", t_ack, t_rise + 1); end
        n_cmp++; if (n_ack != 1) begin n_fail++; $display("FAIL busy_ack_count: got %0d want 1", n_ack); end
        n_cmp++; if (xfer_cnt - x0 != 1) begin n_fail++; $display("FAIL busy_xfers: got %0d want 1", xfer_cnt - x0); end
    endtask

    task automatic test_reset_busy();
        bit seen, saw_start;
        int n_ack, got_sel;
        do_reset();
        ctrl_busy = 0;
        for (int k = 0; k < NR; k++) set_data(k, $urandom);
        req = 4'b0010;
        wait_ack(40, seen, saw_start);
        ctrl_busy = 30;
        req = 4'b1111;
        n_ack = 0;
        saw_start = 1'b0;
        for (int i = 0; i < 20 && !saw_start; i++) begin
            @(negedge clk);
            if (spi_start) saw_start = 1'b1;
        end
        n_cmp++; if (dev_sel !== 2'd2) begin n_fail++; $display("FAIL rstbusy_pregrant: got %0d want 2", dev_sel); end
        repeat (4) begin
            @(negedge clk);
            if (ack != '0) n_ack++;
        end
        ctrl_busy = 1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({ack, rsp, err, dev_sel, spi_start, spi_wdata, spi_rst} !== '0) begin
            n_fail++;
            $display("FAIL rstbusy_outputs: got ack=%b rsp=%h err=%b sel=%0d start=%b wdata=%h rst=%b want all 0",
                     ack, rsp, err, dev_sel, spi_start, spi_wdata, spi_rst);
        end
        got_sel = -1;
        for (int i = 0; i < 20 && got_sel < 0; i++) begin
            @(negedge clk);
            if (ack != '0) n_ack++;
            if (spi_start) got_sel = int'(dev_sel);
        end
        n_cmp++; if (n_ack != 0) begin n_fail++; $display("FAIL rstbusy_no_ack: got %0d acks want 0", n_ack); end
        n_cmp++; if (got_sel != 0) begin n_fail++; $display("FAIL rstbusy_regrant: got %0d want 0", got_sel); end
        wait_ack(40, seen, saw_start);
        n_cmp++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL rstbusy_ack: got %b want 0001", ack); end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        int m_ptr, exp_w, n_done, cyc;
        bit in_flight;
        logic prev_start;
        logic [FW-1:0] exp_data, exp_rsp;
        do_reset();
        ctrl_xor = $urandom;
        m_ptr = 0;
        exp_w = 0;
        exp_data = '0;
        n_done = 0;
        in_flight = 1'b0;
        prev_start = 1'b0;
        for (int k = 0; k < NR; k++) set_data(k, $urandom);
        req = NR'($urandom_range(1, 15));
        for (cyc = 0; cyc < 3000 && n_done < 40; cyc++) begin
            @(negedge clk);
            ctrl_busy = $urandom_range(0, 4);
            if (spi_start && !prev_start) begin
                exp_w = rr_pick(req, m_ptr);
                n_cmp++;
                if (exp_w < 0 || int'(dev_sel) != exp_w) begin
                    n_fail++; $display("FAIL rand_grant: got %0d want %0d (req %b ptr %0d)", dev_sel, exp_w, req, m_ptr);
                end
                if (exp_w < 0) exp_w = 0;
                exp_data = get_data(exp_w);
                n_cmp++;
                if (spi_wdata !== exp_data) begin
                    n_fail++; $display("FAIL rand_txdata: got %h want %h", spi_wdata, exp_data);
                end
                in_flight = 1'b1;
                // Requester walks away after grant and scribbles its frame.
                if ($urandom_range(0, 3) == 0) begin
                    req[exp_w] = 1'b0;
                    set_data(exp_w, $urandom);
                end
            end
            prev_start = spi_start;
            if (ack != '0) begin
                exp_rsp = exp_data ^ ctrl_xor;
                n_cmp++;
                if (!in_flight || ack !== (NR'(1) << exp_w) || rsp !== exp_rsp || err !== 1'b0 ||
                    spi_wdata !== exp_data || int'(dev_sel) != exp_w) begin
                    n_fail++;
                    $display("FAIL rand_ack: got ack=%b rsp=%h err=%b sel=%0d wdata=%h want ack idx %0d rsp=%h err=0 wdata=%h",
                             ack, rsp, err, dev_sel, spi_wdata, exp_w, exp_rsp, exp_data);
                end
                in_flight = 1'b0;
                m_ptr = (exp_w + 1) % NR;
                n_done++;
                if (req[exp_w]) begin
                    if ($urandom_range(0, 1) == 0) req[exp_w] = 1'b0;
                    else set_data(exp_w, $urandom);
                end
                for (int k = 0; k < NR; k++) begin
                    if (k != exp_w && !req[k] && $urandom_range(0, 2) == 0) begin
                        req[k] = 1'b1;
                        set_data(k, $urandom);
                    end
                end
                if (req == '0) begin
                    req = NR'($urandom_range(1, 15));
                    for (int k = 0; k < NR; k++) if (req[k]) set_data(k, $urandom);
                end
            end
        end
        n_cmp++; if (n_done < 40) begin n_fail++; $display("FAIL rand_progress: got %0d acks want 40", n_done); end
        req = '0;
        repeat (8) @(negedge clk);
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n_rst, t_ack;
        bit seen, saw_start;
        logic ack_err, rst_with_ack;
        logic [FW-1:0] ack_rsp;
        logic [NR-1:0] ack_val;
        do_reset();
        ctrl_stuck = 1'b1;
        set_data(0, $urandom | 32'h1);
        n_rst = 0; t_ack = -1;
        ack_err = 1'b0; rst_with_ack = 1'b0; ack_rsp = 'x; ack_val = '0;
        req = 4'b0001;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (spi_rst) n_rst++;
            if (ack != '0 && t_ack < 0) begin
                t_ack = t;
                ack_val = ack;
                ack_err = err;
                ack_rsp = rsp;
                rst_with_ack = spi_rst;
                req = '0;
            end
        end
        n_cmp++; if (n_rst != 1) begin n_fail++; $display("FAIL to_rst_count: got %0d want 1", n_rst); end
        n_cmp++; if (ack_val !== 4'b0001) begin n_fail++; $display("FAIL to_ack: got %b want 0001", ack_val); end
        n_cmp++; if (ack_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", ack_err); end
        n_cmp++; if (ack_rsp !== '0) begin n_fail++; $display("FAIL to_rsp: got %h want 0", ack_rsp); end
        n_cmp++; if (rst_with_ack !== 1'b1) begin n_fail++; $display("FAIL to_rst_align: got %b want 1", rst_with_ack); end
        n_cmp++;
        if (t_ack < TO - 2 || t_ack > TO + 3) begin
            n_fail++; $display("FAIL to_latency: got %0d want %0d..%0d", t_ack, TO - 2, TO + 3);
        end
        ctrl_stuck = 1'b0;
        ctrl_busy = 1;
        req = 4'b0010;
        wait_ack(40, seen, saw_start);
        n_cmp++;
        if (ack !== 4'b0010 || err !== 1'b0) begin
            n_fail++; $display("FAIL to_recover: got ack=%b err=%b want 0010 err=0", ack, err);
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        reset = 1'b1;
        req = '0;
        req_data = '0;
        test_reset();
        test_single();
        test_all_four();
        test_ptr2();
        test_busy_hold();
        test_reset_busy();
        test_random();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
